// File: rtl/riscv_pipeline_ctrl_pkg.sv
// Shared state encodings and helpers for the pipeline stall/flush sequencer.
package riscv_pipeline_ctrl_pkg;

    localparam logic [1:0] PIPE_ST_RUN      = 2'd0;
    localparam logic [1:0] PIPE_ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] PIPE_ST_FLUSH    = 2'd2;

    localparam int unsigned FLUSH_CNT_W = 3;

    typedef struct packed {
        logic en;
        logic clr;
    } stage_ctrl_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/riscv_pipe_hazard_detect.sv
// Load-use hazard compare between the EX-stage load destination and ID-stage sources.
module riscv_pipe_hazard_detect (
    input  logic       i_ex_is_load,
    input  logic [4:0] i_ex_rd,
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_id_use_rs1,
    input  logic       i_id_use_rs2,
    output logic       o_load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
    assign rs2_hit = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);

    // x0 never carries a real dependency.
    assign o_load_use = i_ex_is_load && (i_ex_rd != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/riscv_pipeline_ctrl.sv
// Stall/flush sequencer driving per-stage enable/clear pairs and the PC hold line.
// Optional RISCV_PIPE_PERF_EN adds saturating stall and flush event counters.
module riscv_pipeline_ctrl
    import riscv_pipeline_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter bit          TRAP_CLR_ALL = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic [4:0]  i_id_rs1,
    input  logic [4:0]  i_id_rs2,
    input  logic        i_id_use_rs1,
    input  logic        i_id_use_rs2,
    input  logic [4:0]  i_ex_rd,
    input  logic        i_ex_is_load,
    input  logic        i_ex_br_taken,
    input  logic        i_trap,
    input  logic        i_dmem_req,
    input  logic        i_dmem_ack,
    output logic        o_pc_hold,
    output logic        o_ifid_en,
    output logic        o_ifid_clr,
    output logic        o_idex_en,
    output logic        o_idex_clr,
    output logic        o_exmem_en,
    output logic        o_exmem_clr,
    output logic        o_memwb_en,
    output logic        o_memwb_clr,
    output logic [1:0]  o_state
`ifdef RISCV_PIPE_PERF_EN
    ,
    output logic [31:0] o_stall_cnt,
    output logic [31:0] o_flush_cnt
`endif
);

    localparam logic [FLUSH_CNT_W-1:0] TRAP_RELOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [FLUSH_CNT_W-1:0] BR_RELOAD   =
        (FLUSH_CYCLES > 1) ? FLUSH_CNT_W'(FLUSH_CYCLES - 2) : '0;
    localparam logic [1:0] REDIRECT_ST = (FLUSH_CYCLES > 1) ? PIPE_ST_FLUSH : PIPE_ST_RUN;

    logic [1:0]             state_q, state_d;
    logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
    stage_ctrl_t            ifid, idex, exmem, memwb;
    logic                   pc_hold;
    logic                   load_use;
    logic                   dmem_wait;
    logic                   flush_evt;

    riscv_pipe_hazard_detect u_hazard (
        .i_ex_is_load (i_ex_is_load),
        .i_ex_rd      (i_ex_rd),
        .i_id_rs1     (i_id_rs1),
        .i_id_rs2     (i_id_rs2),
        .i_id_use_rs1 (i_id_use_rs1),
        .i_id_use_rs2 (i_id_use_rs2),
        .o_load_use   (load_use)
    );

    assign dmem_wait = i_dmem_req && !i_dmem_ack;

    always_comb begin
        ifid      = '{en: 1'b1, clr: 1'b0};
        idex      = '{en: 1'b1, clr: 1'b0};
        exmem     = '{en: 1'b1, clr: 1'b0};
        memwb     = '{en: 1'b1, clr: 1'b0};
        pc_hold   = 1'b0;
        state_d   = state_q;
        cnt_d     = cnt_q;
        flush_evt = 1'b0;

        if (i_trap) begin
            ifid.clr  = 1'b1;
            idex.clr  = 1'b1;
            if (TRAP_CLR_ALL) begin
                exmem.clr = 1'b1;
                memwb.clr = 1'b1;
            end
            state_d   = REDIRECT_ST;
            cnt_d     = TRAP_RELOAD;
            flush_evt = 1'b1;
        end else if (dmem_wait) begin
            // Freeze everything upstream of MEM and push a bubble into WB.
            pc_hold   = 1'b1;
            ifid.en   = 1'b0;
            idex.en   = 1'b0;
            exmem.en  = 1'b0;
            memwb.clr = 1'b1;
            state_d   = PIPE_ST_MEM_WAIT;
        end else if (i_ex_br_taken) begin
            ifid.clr  = 1'b1;
            idex.clr  = 1'b1;
            state_d   = REDIRECT_ST;
            cnt_d     = BR_RELOAD;
            flush_evt = 1'b1;
        end else begin
            if (state_q == PIPE_ST_FLUSH) begin
                ifid.clr = 1'b1;
                if (cnt_q == '0) begin
                    state_d = PIPE_ST_RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end else begin
                state_d = PIPE_ST_RUN;
            end
            if (load_use) begin
                pc_hold  = 1'b1;
                ifid.en  = 1'b0;
                idex.clr = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= PIPE_ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_pc_hold   = pc_hold;
    assign o_ifid_en   = ifid.en;
    assign o_ifid_clr  = ifid.clr;
    assign o_idex_en   = idex.en;
    assign o_idex_clr  = idex.clr;
    assign o_exmem_en  = exmem.en;
    assign o_exmem_clr = exmem.clr;
    assign o_memwb_en  = memwb.en;
    assign o_memwb_clr = memwb.clr;
    assign o_state     = state_q;

`ifdef RISCV_PIPE_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (pc_hold) begin
                stall_cnt_q <= sat_inc(stall_cnt_q);
            end
            if (flush_evt) begin
                flush_cnt_q <= sat_inc(flush_cnt_q);
            end
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;
`else
    logic unused_flush_evt;
    assign unused_flush_evt = flush_evt;
`endif

endmodule
